// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// hazard_stall_ctrl_if : D/E/M hazard operands and pipeline control outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [4:0] a3_E;
  logic [1:0] tnew_E;
  logic [4:0] a3_M;
  logic [1:0] tnew_M;
  logic       md_use_D;
  logic       md_start_E;
  logic       md_is_div_E;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_clr;
  logic       md_busy;

  modport master (
    output rs_D, rt_D, tuse_rs, tuse_rt, a3_E, tnew_E, a3_M, tnew_M,
    output md_use_D, md_start_E, md_is_div_E,
    input  pc_en, ifid_en, idex_clr, md_busy
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs, tuse_rt, a3_E, tnew_E, a3_M, tnew_M,
    input  md_use_D, md_start_E, md_is_div_E,
    output pc_en, ifid_en, idex_clr, md_busy
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : Tuse/Tnew stall and mult/div busy control, stall counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  hazard_stall_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int BW      = $clog2(MAX_CYC + 1);

  logic [BW-1:0]    r_busy_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_md_busy;
  logic             w_stall_rs_E;
  logic             w_stall_rs_M;
  logic             w_stall_rt_E;
  logic             w_stall_rt_M;
  logic             w_stall_md;
  logic             w_stall;

  assign w_md_busy = (r_busy_cnt != '0);

  // A producer stalls D only when its result arrives later than D needs it.
  assign w_stall_rs_E = (hz.rs_D == hz.a3_E) && (hz.a3_E != 5'd0) && (hz.tuse_rs < hz.tnew_E);
  assign w_stall_rs_M = (hz.rs_D == hz.a3_M) && (hz.a3_M != 5'd0) && (hz.tuse_rs < hz.tnew_M);
  assign w_stall_rt_E = (hz.rt_D == hz.a3_E) && (hz.a3_E != 5'd0) && (hz.tuse_rt < hz.tnew_E);
  assign w_stall_rt_M = (hz.rt_D == hz.a3_M) && (hz.a3_M != 5'd0) && (hz.tuse_rt < hz.tnew_M);
  assign w_stall_md   = hz.md_use_D && (w_md_busy || hz.md_start_E);

  assign w_stall = w_stall_rs_E | w_stall_rs_M | w_stall_rt_E | w_stall_rt_M | w_stall_md;

  assign hz.pc_en    = ~w_stall;
  assign hz.ifid_en  = ~w_stall;
  assign hz.idex_clr = w_stall;
  assign hz.md_busy  = w_md_busy;
  assign stall_cnt   = r_stall_cnt;

  // A new issue reloads even if the unit is still counting down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_cnt <= '0;
    end else if (hz.md_start_E) begin
      r_busy_cnt <= hz.md_is_div_E ? BW'(DIV_CYCLES) : BW'(MULT_CYCLES);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// tb_hazard_stall_ctrl : directed checks of stall decode, mult/div busy, counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  int          n_cmp;
  int          n_err;

  hazard_stall_ctrl_if bus ();
  hazard_stall_ctrl_if bus4 ();

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (bus),
    .stall_cnt (stall_cnt)
  );

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .hz        (bus4),
    .stall_cnt (stall_cnt4)
  );

  // Narrow-counter copy sees exactly the same stimulus as the main instance.
  assign bus4.rs_D        = bus.rs_D;
  assign bus4.rt_D        = bus.rt_D;
  assign bus4.tuse_rs     = bus.tuse_rs;
  assign bus4.tuse_rt     = bus.tuse_rt;
  assign bus4.a3_E        = bus.a3_E;
  assign bus4.tnew_E      = bus.tnew_E;
  assign bus4.a3_M        = bus.a3_M;
  assign bus4.tnew_M      = bus.tnew_M;
  assign bus4.md_use_D    = bus.md_use_D;
  assign bus4.md_start_E  = bus.md_start_E;
  assign bus4.md_is_div_E = bus.md_is_div_E;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_D = 5'd0;  bus.rt_D = 5'd0;
    bus.tuse_rs = 2'd3; bus.tuse_rt = 2'd3;
    bus.a3_E = 5'd0;  bus.tnew_E = 2'd0;
    bus.a3_M = 5'd0;  bus.tnew_M = 2'd0;
    bus.md_use_D = 1'b0; bus.md_start_E = 1'b0; bus.md_is_div_E = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic stalled);
    check({tag, ".pc_en"},    {31'd0, bus.pc_en},    {31'd0, ~stalled});
    check({tag, ".ifid_en"},  {31'd0, bus.ifid_en},  {31'd0, ~stalled});
    check({tag, ".idex_clr"}, {31'd0, bus.idex_clr}, {31'd0, stalled});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_ctrl("reset", 1'b0);
    check("reset.md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("reset.stall_cnt", stall_cnt, 32'd0);

    // rs vs E: needed now, ready next cycle
    bus.rs_D = 5'd8; bus.tuse_rs = 2'd0; bus.a3_E = 5'd8; bus.tnew_E = 2'd1;
    #1 check_ctrl("rs_E", 1'b1);
    step();
    check("rs_E.cnt", stall_cnt, 32'd1);
    bus.a3_E = 5'd0;
    #1 check_ctrl("rs_E_r0", 1'b0);
    step();
    check("rs_E_r0.cnt", stall_cnt, 32'd1);
    clear_inputs();

    // rt vs M
    bus.rt_D = 5'd9; bus.tuse_rt = 2'd1; bus.a3_M = 5'd9; bus.tnew_M = 2'd1;
    #1 check_ctrl("rt_M_ok", 1'b0);
    bus.tuse_rt = 2'd0;
    #1 check_ctrl("rt_M", 1'b1);
    step();
    check("rt_M.cnt", stall_cnt, 32'd2);
    clear_inputs();

    // mult issue with a dependent mult/div user in D
    bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b0; bus.md_use_D = 1'b1;
    #1 check_ctrl("md_start", 1'b1);
    check("md_start.busy", {31'd0, bus.md_busy}, 32'd0);
    step();
    bus.md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        bus.rs_D = 5'd8; bus.tuse_rs = 2'd0; bus.a3_E = 5'd8; bus.tnew_E = 2'd1;
      end else begin
        bus.rs_D = 5'd0; bus.tuse_rs = 2'd3; bus.a3_E = 5'd0; bus.tnew_E = 2'd0;
      end
      #1;
      check($sformatf("md_busy%0d", i), {31'd0, bus.md_busy}, 32'd1);
      check($sformatf("md_pc_en%0d", i), {31'd0, bus.pc_en}, 32'd0);
      step();
    end
    check("md_done.busy", {31'd0, bus.md_busy}, 32'd0);
    check_ctrl("md_done", 1'b0);
    check("md_done.cnt", stall_cnt, 32'd8);
    clear_inputs();

    // div issue, then asynchronous reset between edges
    bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1;
    step();
    bus.md_start_E = 1'b0; bus.md_is_div_E = 1'b0;
    check("div.busy", {31'd0, bus.md_busy}, 32'd1);
    step();
    step();
    check("div.busy3", {31'd0, bus.md_busy}, 32'd1);
    check("div.cnt", stall_cnt, 32'd8);
    #2 reset = 1'b0;
    #1;
    check("async.busy", {31'd0, bus.md_busy}, 32'd0);
    check("async.cnt", stall_cnt, 32'd0);
    check("async.cnt4", {28'd0, stall_cnt4}, 32'd0);
    check_ctrl("async", 1'b0);
    step();
    reset = 1'b1;

    // narrow counter wraps after 16 stalls
    bus.rs_D = 5'd3; bus.tuse_rs = 2'd0; bus.a3_M = 5'd3; bus.tnew_M = 2'd2;
    repeat (15) step();
    check("wrap.cnt4_15", {28'd0, stall_cnt4}, 32'd15);
    step();
    check("wrap.cnt4_0", {28'd0, stall_cnt4}, 32'd0);
    check("wrap.cnt32", stall_cnt, 32'd16);
    clear_inputs();
    #1 check_ctrl("final", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
